// File: rtl/scoreboard_regfile_if.sv
// Operand/write-back bus between decoder, register file and execute stage.
interface scoreboard_regfile_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WB   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     stall_i;
    logic                     issue_valid_i;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*AW-1:0]     rd_addr_i;
    logic [NUM_RD*XLEN-1:0]   rd_data_o;
    logic                     dst_wr_i;
    logic [AW-1:0]            dst_addr_i;
    logic [NUM_WB-1:0]        wb_valid_i;
    logic [NUM_WB*AW-1:0]     wb_addr_i;
    logic [NUM_WB*XLEN-1:0]   wb_data_i;
    logic [NUM_REGS-1:0]      pending_o;
    logic                     stall_o;
    logic                     error_o;

    modport master (
        output stall_i, issue_valid_i, rd_en_i, rd_addr_i, dst_wr_i, dst_addr_i,
               wb_valid_i, wb_addr_i, wb_data_i,
        input  rd_data_o, pending_o, stall_o, error_o
    );

    modport slave (
        input  stall_i, issue_valid_i, rd_en_i, rd_addr_i, dst_wr_i, dst_addr_i,
               wb_valid_i, wb_addr_i, wb_data_i,
        output rd_data_o, pending_o, stall_o, error_o
    );
endinterface

// File: rtl/scoreboard_regfile.sv
// Register file with per-register outstanding-write counters, same-cycle
// write-back bypass, RAW/saturation issue stall and sticky protocol error.
module scoreboard_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WB   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    scoreboard_regfile_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int MW = $clog2(NUM_WB + 1);
    // one extra bit so cnt - m going negative never aliases CNT_MAX
    localparam int SW = ((CNT_W > MW) ? CNT_W : MW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

    logic [NUM_REGS-1:0][XLEN-1:0]  regs;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0][MW-1:0]    m;
    logic [NUM_REGS-1:0][XLEN-1:0]  byp;
    logic [NUM_REGS-1:0][SW-1:0]    post;
    logic [NUM_REGS-1:0]            over;
    logic [NUM_RD-1:0]              rd_rdy;
    logic                           sat;
    logic                           accept;
    logic                           error_q;

    // per-register write-back hit count and highest-indexed port's data
    always_comb begin
        m   = '0;
        byp = '0;
        for (int r = 0; r < NUM_REGS; r++)
            for (int w = 0; w < NUM_WB; w++)
                if (bus.wb_valid_i[w] && bus.wb_addr_i[w*AW +: AW] == AW'(r)) begin
                    m[r]   = m[r] + MW'(1);
                    byp[r] = bus.wb_data_i[w*XLEN +: XLEN];
                end
    end

    // post-write-back count and over-retire detection
    always_comb begin
        post = '0;
        over = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            post[r] = SW'(cnt[r]) - SW'(m[r]);
            over[r] = (r != 0) && (SW'(m[r]) > SW'(cnt[r]));
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic            rdy;
        logic [XLEN-1:0] dat;
        assign a = bus.rd_addr_i[p*AW +: AW];
        // operand select: idle/x0 -> 0, clean -> regfile, fully retired -> bypass
        always_comb begin
            rdy = 1'b1;
            dat = '0;
            if (bus.rd_en_i[p] && a != '0) begin
                if (cnt[a] == '0)
                    dat = regs[a];
                else if (SW'(m[a]) == SW'(cnt[a]))
                    dat = byp[a];
                else
                    rdy = 1'b0;
            end
        end
        assign rd_rdy[p] = rdy;
        assign bus.rd_data_o[p*XLEN +: XLEN] = dat;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        assign bus.pending_o[r] = (cnt[r] != '0);
    end

    assign sat = bus.dst_wr_i && (bus.dst_addr_i != '0) && (post[bus.dst_addr_i] == CNT_MAX);
    assign bus.stall_o = bus.issue_valid_i && (!(&rd_rdy) || sat);
    assign accept = bus.issue_valid_i && !bus.stall_o && !bus.stall_i;
    assign bus.error_o = error_q;

    // register data, scoreboard counters and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs    <= '0;
            cnt     <= '0;
            error_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (m[r] != '0)
                    regs[r] <= byp[r];
                if (over[r])
                    cnt[r] <= '0;
                else
                    cnt[r] <= CNT_W'(post[r] +
                              ((accept && bus.dst_wr_i && bus.dst_addr_i == AW'(r)) ? SW'(1) : SW'(0)));
            end
            if (|over)
                error_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomized + directed check of scoreboard_regfile against a behavioural model.
module tb_scoreboard_regfile;
    localparam int XLEN = 32, NUM_REGS = 32, NUM_RD = 2, NUM_WB = 2, CNT_W = 2;
    localparam int AW = 5;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    scoreboard_regfile_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WB(NUM_WB)) bus();
    scoreboard_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WB(NUM_WB), .CNT_W(CNT_W))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0, errors = 0;
    logic [XLEN-1:0] mregs [NUM_REGS];
    int              mcnt  [NUM_REGS];
    logic            merr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin mregs[r] = '0; mcnt[r] = 0; end
        merr = 1'b0;
    endtask

    function automatic int hits(input int r);
        int n = 0;
        for (int w = 0; w < NUM_WB; w++)
            if (bus.wb_valid_i[w] && int'(bus.wb_addr_i[w*AW +: AW]) == r) n++;
        return n;
    endfunction

    function automatic logic [XLEN-1:0] last_wb(input int r);
        logic [XLEN-1:0] d = '0;
        for (int w = 0; w < NUM_WB; w++)
            if (bus.wb_valid_i[w] && int'(bus.wb_addr_i[w*AW +: AW]) == r) d = bus.wb_data_i[w*XLEN +: XLEN];
        return d;
    endfunction

    function automatic logic exp_stall();
        logic nr = 0;
        int d = int'(bus.dst_addr_i);
        for (int p = 0; p < NUM_RD; p++) begin
            int a = int'(bus.rd_addr_i[p*AW +: AW]);
            if (bus.rd_en_i[p] && a != 0 && mcnt[a] != 0 && hits(a) != mcnt[a]) nr = 1;
        end
        return bus.issue_valid_i && (nr || (bus.dst_wr_i && d != 0 && mcnt[d] - hits(d) == MAXC));
    endfunction

    // compare every DUT output against the model with current inputs
    task automatic settle();
        logic [NUM_REGS-1:0] pend;
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            int a = int'(bus.rd_addr_i[p*AW +: AW]);
            logic [XLEN-1:0] e = '0;
            if (bus.rd_en_i[p] && a != 0) begin
                if (mcnt[a] == 0) e = mregs[a];
                else if (hits(a) == mcnt[a]) e = last_wb(a);
            end
            chk($sformatf("rd_data%0d", p), bus.rd_data_o[p*XLEN +: XLEN], e);
        end
        for (int r = 0; r < NUM_REGS; r++) pend[r] = (mcnt[r] != 0);
        chk("stall_o", bus.stall_o, exp_stall());
        chk("pending_o", bus.pending_o, pend);
        chk("error_o", bus.error_o, merr);
    endtask

    task automatic advance();
        logic acc;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            acc = bus.issue_valid_i && !exp_stall() && !bus.stall_i;
            for (int r = 1; r < NUM_REGS; r++) begin
                int h = hits(r);
                int inc = (acc && bus.dst_wr_i && int'(bus.dst_addr_i) == r) ? 1 : 0;
                if (h > 0) mregs[r] = last_wb(r);
                if (h > mcnt[r]) begin mcnt[r] = 0; merr = 1'b1; end
                else mcnt[r] = mcnt[r] - h + inc;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        bus.stall_i = 0; bus.issue_valid_i = 0; bus.rd_en_i = '0; bus.rd_addr_i = '0;
        bus.dst_wr_i = 0; bus.dst_addr_i = '0; bus.wb_valid_i = '0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en_i[p] = 1; bus.rd_addr_i[p*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int d);
        bus.issue_valid_i = 1; bus.dst_wr_i = 1; bus.dst_addr_i = AW'(d);
    endtask

    task automatic wb(input int w, input int a, input logic [XLEN-1:0] d);
        bus.wb_valid_i[w] = 1; bus.wb_addr_i[w*AW +: AW] = AW'(a); bus.wb_data_i[w*XLEN +: XLEN] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        int used [8];
        model_reset();
        idle();
        // reset state
        rd(0, 5); rd(1, 0);
        @(negedge clk);
        settle();
        chk("rst_rd0", bus.rd_data_o[31:0], 0);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_pend", bus.pending_o, 0);
        advance();
        rst = 0;
        @(negedge clk);

        // RAW on x3 resolved by same-cycle bypass
        idle(); issue(3); step();
        idle(); rd(0, 3); bus.issue_valid_i = 1; settle();
        chk("raw_stall", bus.stall_o, 1); advance();
        wb(0, 3, 32'hDEADBEEF); settle();
        chk("byp_data", bus.rd_data_o[31:0], 32'hDEADBEEF);
        chk("byp_stall", bus.stall_o, 0); advance();
        idle(); settle(); chk("x3_clear", bus.pending_o[3], 0); advance();

        // saturation on x7 with retiring write-back
        idle(); issue(7); step(); step(); step();
        settle(); chk("sat_stall", bus.stall_o, 1);
        wb(0, 7, 32'h77); settle(); chk("sat_wb_stall", bus.stall_o, 0); advance();
        idle(); rd(0, 7); bus.issue_valid_i = 1; settle(); chk("x7_pend", bus.pending_o[7], 1);
        advance();
        idle(); wb(0, 7, 1); wb(1, 7, 2); step();
        idle(); wb(1, 7, 3); step();

        // dual write-back to x9, highest port wins
        idle(); issue(9); step(); step();
        idle(); wb(0, 9, 32'h11); wb(1, 9, 32'h22); step();
        idle(); rd(1, 9); settle();
        chk("x9_data", bus.rd_data_o[63:32], 32'h22);
        chk("x9_err", bus.error_o, 0); advance();

        // over-retire and x0 write
        idle(); wb(0, 4, 32'h44); wb(1, 0, 32'hFF); step();
        idle(); rd(0, 4); rd(1, 0); settle();
        chk("err_set", bus.error_o, 1);
        chk("x4_data", bus.rd_data_o[31:0], 32'h44);
        chk("x0_data", bus.rd_data_o[63:32], 0); advance();

        // external stall blocks acceptance
        idle(); issue(6); bus.stall_i = 1; step();
        settle(); chk("x6_held", bus.pending_o[6], 0);
        bus.stall_i = 0; advance();
        idle(); settle(); chk("x6_pend", bus.pending_o[6], 1); advance();
        idle(); wb(0, 6, 32'h66); step();

        // asynchronous reset mid-stream with cnt[3] = 2
        idle(); issue(3); step(); step();
        idle(); settle(); chk("x3_pend2", bus.pending_o[3], 1);
        #2 rst = 1; #1;
        model_reset();
        chk("async_pend3", bus.pending_o[3], 0);
        chk("async_err", bus.error_o, 0);
        @(negedge clk); step();
        rst = 0;

        // randomized traffic over x0..x7
        for (int i = 0; i < 600; i++) begin
            idle();
            for (int k = 0; k < 8; k++) used[k] = 0;
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.issue_valid_i = $urandom_range(0, 1);
            bus.dst_wr_i = $urandom_range(0, 1);
            bus.dst_addr_i = AW'($urandom_range(0, 7));
            for (int p = 0; p < NUM_RD; p++)
                if ($urandom_range(0, 1)) rd(p, $urandom_range(0, 7));
            for (int w = 0; w < NUM_WB; w++) begin
                int a = $urandom_range(0, 7);
                if ($urandom_range(0, 1) && (mcnt[a] > used[a] || $urandom_range(0, 30) == 0)) begin
                    used[a]++;
                    wb(w, a, $urandom);
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
